// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a sop/eop-delimited byte stream into DW-bit words
// Malformed framing is absorbed here: strays are dropped, a mid-frame sop flushes an err word.
module byte_word_packer #(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int CW = $clog2(NB) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    din_i,
  input  logic          din_sop_i,
  input  logic          din_eop_i,
  input  logic          din_vld_i,
  output logic          din_rdy_o,
  output logic [DW-1:0] dout_o,
  output logic [CW-1:0] dout_cnt_o,
  output logic          dout_sop_o,
  output logic          dout_eop_o,
  output logic          dout_err_o,
  output logic          dout_vld_o,
  input  logic          dout_rdy_i,
  output logic          drop_o
);

  localparam int IW = $clog2(NB);
  localparam int AW = 8 * (NB - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t        state, state_n;
  logic [AW-1:0] acc, acc_n;
  logic [IW-1:0] idx, idx_n;
  logic          acc_sop, acc_sop_n;
  logic          drop_n;

  logic          load;
  logic [DW-1:0] ld_data;
  logic [CW-1:0] ld_cnt;
  logic          ld_sop, ld_eop, ld_err;

  logic          out_free, abort, accept, last_lane;
  logic [DW-1:0] merged;

  assign out_free  = !dout_vld_o || dout_rdy_i;
  assign abort     = (state == FILL) && din_vld_i && din_sop_i;
  // Stall every byte while the output is blocked, not only word-completing ones.
  assign din_rdy_o = out_free && !abort;
  assign accept    = din_vld_i && din_rdy_o;
  assign last_lane = (idx == IW'(NB - 1));

  always_comb begin
    merged = DW'(acc);
    merged[{idx, 3'b000} +: 8] = din_i;
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    idx_n     = idx;
    acc_sop_n = acc_sop;
    drop_n    = 1'b0;
    load      = 1'b0;
    ld_data   = merged;
    ld_cnt    = CW'(idx) + CW'(1);
    ld_sop    = acc_sop;
    ld_eop    = din_eop_i;
    ld_err    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!din_sop_i) begin
            drop_n = 1'b1;
          end else if (din_eop_i) begin
            load    = 1'b1;
            ld_data = DW'(din_i);
            ld_cnt  = CW'(1);
            ld_sop  = 1'b1;
          end else begin
            acc_n     = AW'(din_i);
            acc_sop_n = 1'b1;
            idx_n     = IW'(1);
            state_n   = FILL;
          end
        end
      end
      FILL: begin
        if (abort) begin
          // The sop byte stays on the input; it opens the next frame from IDLE.
          if (out_free) begin
            load      = 1'b1;
            ld_data   = DW'(acc);
            ld_cnt    = CW'(idx);
            ld_eop    = 1'b1;
            ld_err    = 1'b1;
            acc_n     = '0;
            idx_n     = '0;
            acc_sop_n = 1'b0;
            state_n   = IDLE;
          end
        end else if (accept) begin
          if (last_lane || din_eop_i) begin
            load      = 1'b1;
            acc_n     = '0;
            idx_n     = '0;
            acc_sop_n = 1'b0;
            if (din_eop_i) state_n = IDLE;
          end else begin
            acc_n = merged[AW-1:0];
            idx_n = idx + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      acc_sop    <= 1'b0;
      drop_o     <= 1'b0;
      dout_o     <= '0;
      dout_cnt_o <= '0;
      dout_sop_o <= 1'b0;
      dout_eop_o <= 1'b0;
      dout_err_o <= 1'b0;
      dout_vld_o <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      idx     <= idx_n;
      acc_sop <= acc_sop_n;
      drop_o  <= drop_n;
      if (load) begin
        dout_o     <= ld_data;
        dout_cnt_o <= ld_cnt;
        dout_sop_o <= ld_sop;
        dout_eop_o <= ld_eop;
        dout_err_o <= ld_err;
        dout_vld_o <= 1'b1;
      end else if (dout_rdy_i) begin
        dout_vld_o <= 1'b0;
      end
    end
  end

endmodule
